id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/fwd_select.sv | 50 +++++
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: data width, register-class tags, fpoint encodings
// and control-field bit positions for the ID/EX stage.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 4;

    localparam logic CLS_INT = 1'b0;
    localparam logic CLS_FP  = 1'b1;

    // Only FPT_FP reads FP sources; bit 0 alone selects the destination file.
    typedef enum logic [1:0] {
        FPT_INT     = 2'd0,
        FPT_FP      = 2'd1,
        FPT_INT_ALT = 2'd2,
        FPT_TO_FP   = 2'd3
    } fpoint_e;

    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_FPT_HI   = 1;
    localparam int CTRL_FPT_LO   = 0;

    typedef struct packed {
        logic             cls;
        logic [REG_W-1:0] num;
    } reg_tag_t;

    function automatic logic src_cls(input logic [CTRL_W-1:0] ctrl);
        return (ctrl[CTRL_FPT_HI:CTRL_FPT_LO] == FPT_FP) ? CLS_FP : CLS_INT;
    endfunction

    function automatic logic dst_cls(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_FPT_LO] ? CLS_FP : CLS_INT;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source match and priority selection. With ID_EX_FORWARD_EN defined it
// forwards EX/MEM then MEM/WB and flags load-use; otherwise it flags any match.
module fwd_select
    import pipe_pkg::*;
(
    input  reg_tag_t          src_tag_i,
    input  logic              idex_we_i,
    input  logic              idex_memread_i,
    input  reg_tag_t          idex_tag_i,
    input  logic              exmem_we_i,
    input  reg_tag_t          exmem_tag_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_we_i,
    input  reg_tag_t          memwb_tag_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    input  logic [DATA_W-1:0] bus_i,
    output logic [DATA_W-1:0] operand_o,
    output logic              hazard_o
);

    logic idex_hit;
    logic exmem_hit;
    logic memwb_hit;

    // Class and number must both agree; register 0 is not special.
    assign idex_hit  = idex_we_i  && (idex_tag_i  == src_tag_i);
    assign exmem_hit = exmem_we_i && (exmem_tag_i == src_tag_i);
    assign memwb_hit = memwb_we_i && (memwb_tag_i == src_tag_i);

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        // NOTE: default first so every path assigns operand_o and no latch is inferred.
        operand_o = bus_i;
        if (exmem_hit) begin
            operand_o = exmem_result_i;
        end else if (memwb_hit) begin
            operand_o = memwb_result_i;
        end
    end

    assign hazard_o = idex_hit && idex_memread_i;
`else
    logic unused_fwd;
    assign unused_fwd = ^{idex_memread_i, exmem_result_i, memwb_result_i};

    assign operand_o = bus_i;
    assign hazard_o  = idex_hit || exmem_hit || memwb_hit;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand resolution, hazard stall and a
// saturating stall counter. Optional feature macro: ID_EX_FORWARD_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rw,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] busA,
    input  logic [DATA_W-1:0] busB,
    input  logic              exmem_we,
    input  logic [REG_W:0]    exmem_tag,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_we,
    input  logic [REG_W:0]    memwb_tag,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rw,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_opa_q, ex_opa_d;
    logic [DATA_W-1:0] ex_opb_q, ex_opb_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [REG_W-1:0]  ex_rw_q, ex_rw_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    reg_tag_t          src_a_tag, src_b_tag, idex_tag;
    logic              idex_we;
    logic [DATA_W-1:0] opa_res, opb_res;
    logic              haz_a, haz_b;

    assign src_a_tag = {src_cls(id_ctrl), id_rs};
    assign src_b_tag = {src_cls(id_ctrl), id_rt};
    assign idex_tag  = {dst_cls(ex_ctrl_q), ex_rw_q};
    assign idex_we   = ex_valid_q && ex_ctrl_q[CTRL_REGWRITE];

    fwd_select u_fwd_a (
        .src_tag_i      (src_a_tag),
        .idex_we_i      (idex_we),
        .idex_memread_i (ex_ctrl_q[CTRL_MEMREAD]),
        .idex_tag_i     (idex_tag),
        .exmem_we_i     (exmem_we),
        .exmem_tag_i    (reg_tag_t'(exmem_tag)),
        .exmem_result_i (exmem_result),
        .memwb_we_i     (memwb_we),
        .memwb_tag_i    (reg_tag_t'(memwb_tag)),
        .memwb_result_i (memwb_result),
        .bus_i          (busA),
        .operand_o      (opa_res),
        .hazard_o       (haz_a)
    );

    fwd_select u_fwd_b (
        .src_tag_i      (src_b_tag),
        .idex_we_i      (idex_we),
        .idex_memread_i (ex_ctrl_q[CTRL_MEMREAD]),
        .idex_tag_i     (idex_tag),
        .exmem_we_i     (exmem_we),
        .exmem_tag_i    (reg_tag_t'(exmem_tag)),
        .exmem_result_i (exmem_result),
        .memwb_we_i     (memwb_we),
        .memwb_tag_i    (reg_tag_t'(memwb_tag)),
        .memwb_result_i (memwb_result),
        .bus_i          (busB),
        .operand_o      (opb_res),
        .hazard_o       (haz_b)
    );

    assign stall_out = (haz_a || haz_b) && id_valid && !flush;

    always_comb begin
        ex_valid_d = id_valid;
        ex_opa_d   = opa_res;
        ex_opb_d   = opb_res;
        ex_imm_d   = id_imm;
        ex_rw_d    = id_rw;
        ex_ctrl_d  = id_ctrl;
        // Flush and stall both insert a bubble; data fields keep their old values.
        if (flush || stall_out) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_opa_d   = ex_opa_q;
            ex_opb_d   = ex_opb_q;
            ex_imm_d   = ex_imm_q;
            ex_rw_d    = ex_rw_q;
        end

        cnt_d = cnt_q;
        if (stall_out && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_opa_q   <= '0;
            ex_opb_q   <= '0;
            ex_imm_q   <= '0;
            ex_rw_q    <= '0;
            ex_ctrl_q  <= '0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_opa_q   <= ex_opa_d;
            ex_opb_q   <= ex_opb_d;
            ex_imm_q   <= ex_imm_d;
            ex_rw_q    <= ex_rw_d;
            ex_ctrl_q  <= ex_ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_opA      = ex_opa_q;
    assign ex_opB      = ex_opb_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rw       = ex_rw_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; mode-specific scenarios follow ID_EX_FORWARD_EN.
`timescale 1ns/1ps
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rw = '0;
    logic [3:0]  id_ctrl = '0;
    logic [31:0] id_imm = '0, busA = '0, busB = '0;
    logic        exmem_we = 1'b0, memwb_we = 1'b0;
    logic [5:0]  exmem_tag = '0, memwb_tag = '0;
    logic [31:0] exmem_result = '0, memwb_result = '0;

    logic        stall_out, ex_valid;
    logic [31:0] ex_opA, ex_opB, ex_imm;
    logic [4:0]  ex_rw;
    logic [3:0]  ex_ctrl;
    logic [15:0] stall_count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rw        (id_rw),
        .id_ctrl      (id_ctrl),
        .id_imm       (id_imm),
        .busA         (busA),
        .busB         (busB),
        .exmem_we     (exmem_we),
        .exmem_tag    (exmem_tag),
        .exmem_result (exmem_result),
        .memwb_we     (memwb_we),
        .memwb_tag    (memwb_tag),
        .memwb_result (memwb_result),
        .stall_out    (stall_out),
        .ex_valid     (ex_valid),
        .ex_opA       (ex_opA),
        .ex_opB       (ex_opB),
        .ex_imm       (ex_imm),
        .ex_rw        (ex_rw),
        .ex_ctrl      (ex_ctrl),
        .stall_count  (stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rw, input logic [3:0] ctrl);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_rw    = rw;
        id_ctrl  = ctrl;
        #1;
    endtask

    task automatic clear_pipe();
        exmem_we = 1'b0;
        memwb_we = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle_cycle();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 4'b0000);
        tick();
    endtask

    // Puts a load (ctrl carries memread/regwrite/fpoint) into ID/EX.
    task automatic issue_load(input logic [4:0] rw, input logic [3:0] ctrl);
        drive_id(1'b1, 5'd20, 5'd21, rw, ctrl);
        tick();
    endtask

    task automatic test_reset();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 4'b1111);
        id_imm = 32'hDEAD_BEEF;
        busA   = 32'hCAFE_0001;
        busB   = 32'hCAFE_0002;
        tick();
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
        n_checks++; if (ex_opA !== 32'h0) begin n_fail++; $display("FAIL reset_ex_opA: got %h want 0", ex_opA); end
        n_checks++; if (ex_opB !== 32'h0) begin n_fail++; $display("FAIL reset_ex_opB: got %h want 0", ex_opB); end
        n_checks++; if (ex_imm !== 32'h0) begin n_fail++; $display("FAIL reset_ex_imm: got %h want 0", ex_imm); end
        n_checks++; if (ex_rw !== 5'd0) begin n_fail++; $display("FAIL reset_ex_rw: got %0d want 0", ex_rw); end
        n_checks++; if (ex_ctrl !== 4'h0) begin n_fail++; $display("FAIL reset_ex_ctrl: got %h want 0", ex_ctrl); end
        n_checks++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL reset_stall_count: got %h want 0", stall_count); end
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall_out: got %0b want 0", stall_out); end
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 4'b0000);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        drive_id(1'b1, 5'd1, 5'd2, 5'd7, 4'b0100);
        id_imm = 32'hFFFF_FFF0;
        busA   = 32'h0000_00A5;
        busB   = 32'h0000_005A;
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL pass_stall: got %0b want 0", stall_out); end
        tick();
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid: got %0b want 1", ex_valid); end
        n_checks++; if (ex_opA !== 32'h0000_00A5) begin n_fail++; $display("FAIL pass_opA: got %h want 000000a5", ex_opA); end
        n_checks++; if (ex_opB !== 32'h0000_005A) begin n_fail++; $display("FAIL pass_opB: got %h want 0000005a", ex_opB); end
        n_checks++; if (ex_imm !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL pass_imm: got %h want fffffff0", ex_imm); end
        n_checks++; if (ex_rw !== 5'd7) begin n_fail++; $display("FAIL pass_rw: got %0d want 7", ex_rw); end
        n_checks++; if (ex_ctrl !== 4'b0100) begin n_fail++; $display("FAIL pass_ctrl: got %b want 0100", ex_ctrl); end
        idle_cycle();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL pass_idle_valid: got %0b want 0", ex_valid); end
    endtask

    task automatic test_class();
        issue_load(5'd4, 4'b1101);
        drive_id(1'b1, 5'd10, 5'd4, 5'd1, 4'b0000);
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL class_int_vs_fp: got %0b want 0", stall_out); end
        drive_id(1'b1, 5'd4, 5'd10, 5'd1, 4'b0001);
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL class_fp_vs_fp: got %0b want 1", stall_out); end
        drive_id(1'b1, 5'd4, 5'd10, 5'd1, 4'b0011);
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL class_fpt3_src_int: got %0b want 0", stall_out); end
        drive_id(1'b0, 5'd4, 5'd10, 5'd1, 4'b0001);
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL class_id_invalid: got %0b want 0", stall_out); end
        tick();
        issue_load(5'd0, 4'b1100);
        drive_id(1'b1, 5'd0, 5'd5, 5'd1, 4'b0000);
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL class_reg0: got %0b want 1", stall_out); end
        idle_cycle();
        n_checks++; if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL class_count: got %h want %h", stall_count, exp_cnt); end
    endtask

    task automatic test_flush();
        issue_load(5'd4, 4'b1100);
        drive_id(1'b1, 5'd9, 5'd4, 5'd2, 4'b0100);
        flush = 1'b1;
        #1;
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b want 0", stall_out); end
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", ex_valid); end
        n_checks++; if (ex_ctrl !== 4'h0) begin n_fail++; $display("FAIL flush_ctrl: got %b want 0000", ex_ctrl); end
        n_checks++; if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL flush_count: got %h want %h", stall_count, exp_cnt); end
        flush = 1'b0;
        idle_cycle();
    endtask

`ifdef ID_EX_FORWARD_EN
    task automatic test_fwd_priority();
        clear_pipe();
        drive_id(1'b1, 5'd3, 5'd9, 5'd1, 4'b0100);
        busA = 32'd5;
        busB = 32'h77;
        exmem_we = 1'b1; exmem_tag = 6'b0_00011; exmem_result = 32'h11;
        memwb_we = 1'b1; memwb_tag = 6'b0_00011; memwb_result = 32'h22;
        #1;
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL prio_stall: got %0b want 0", stall_out); end
        tick();
        n_checks++; if (ex_opA !== 32'h11) begin n_fail++; $display("FAIL prio_exmem_first: got %h want 00000011", ex_opA); end
        n_checks++; if (ex_opB !== 32'h77) begin n_fail++; $display("FAIL prio_busB: got %h want 00000077", ex_opB); end
        exmem_we = 1'b0;
        tick();
        n_checks++; if (ex_opA !== 32'h22) begin n_fail++; $display("FAIL prio_memwb: got %h want 00000022", ex_opA); end
        clear_pipe();
        idle_cycle();
    endtask

    task automatic test_fwd_class();
        drive_id(1'b1, 5'd3, 5'd9, 5'd1, 4'b0100);
        exmem_we = 1'b1; exmem_tag = 6'b1_00011; exmem_result = 32'h33;
        memwb_we = 1'b1; memwb_tag = 6'b0_00011; memwb_result = 32'h22;
        tick();
        n_checks++; if (ex_opA !== 32'h22) begin n_fail++; $display("FAIL fclass_int: got %h want 00000022", ex_opA); end
        drive_id(1'b1, 5'd3, 5'd9, 5'd1, 4'b0101);
        tick();
        n_checks++; if (ex_opA !== 32'h33) begin n_fail++; $display("FAIL fclass_fp: got %h want 00000033", ex_opA); end
        clear_pipe();
        idle_cycle();
    endtask

    task automatic test_load_use();
        issue_load(5'd4, 4'b1100);
        drive_id(1'b1, 5'd1, 5'd4, 5'd2, 4'b0100);
        busB = 32'h99;
        #1;
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b want 1", stall_out); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %0b want 0", ex_valid); end
        n_checks++; if (ex_ctrl !== 4'h0) begin n_fail++; $display("FAIL lu_bubble_ctrl: got %b want 0000", ex_ctrl); end
        n_checks++; if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL lu_count: got %h want %h", stall_count, exp_cnt); end
        memwb_we = 1'b1; memwb_tag = 6'b0_00100; memwb_result = 32'hBEEF;
        #1;
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %0b want 0", stall_out); end
        tick();
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_issue_valid: got %0b want 1", ex_valid); end
        n_checks++; if (ex_opB !== 32'hBEEF) begin n_fail++; $display("FAIL lu_fwd_opB: got %h want 0000beef", ex_opB); end
        n_checks++; if (ex_rw !== 5'd2) begin n_fail++; $display("FAIL lu_rw: got %0d want 2", ex_rw); end
        clear_pipe();
        idle_cycle();
    endtask
`else
    task automatic test_no_fwd();
        clear_pipe();
        drive_id(1'b1, 5'd20, 5'd21, 5'd7, 4'b0100);
        tick();
        drive_id(1'b1, 5'd7, 5'd21, 5'd1, 4'b0000);
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL nf_idex_stall: got %0b want 1", stall_out); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL nf_idex_bubble: got %0b want 0", ex_valid); end
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL nf_idex_release: got %0b want 0", stall_out); end
        idle_cycle();
        drive_id(1'b1, 5'd3, 5'd9, 5'd1, 4'b0000);
        busA = 32'd5;
        exmem_we = 1'b1; exmem_tag = 6'b0_00011; exmem_result = 32'h11;
        #1;
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL nf_exmem_stall: got %0b want 1", stall_out); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        exmem_we = 1'b0;
        memwb_we = 1'b1; memwb_tag = 6'b0_00011; memwb_result = 32'h11;
        #1;
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL nf_memwb_stall: got %0b want 1", stall_out); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        memwb_we = 1'b0;
        #1;
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL nf_release: got %0b want 0", stall_out); end
        tick();
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL nf_valid: got %0b want 1", ex_valid); end
        n_checks++; if (ex_opA !== 32'd5) begin n_fail++; $display("FAIL nf_opA_bus: got %h want 00000005", ex_opA); end
        n_checks++; if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL nf_count: got %h want %h", stall_count, exp_cnt); end
        idle_cycle();
    endtask

    task automatic test_saturation();
        drive_id(1'b1, 5'd3, 5'd9, 5'd1, 4'b0000);
        exmem_we = 1'b1; exmem_tag = 6'b0_00011;
        #1;
        for (int i = 0; i < 65536; i++) begin
            tick();
        end
        n_checks++; if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", stall_count); end
        tick();
        n_checks++; if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", stall_count); end
        clear_pipe();
        idle_cycle();
    endtask
`endif

    task automatic test_reset_mid_stall();
        clear_pipe();
        issue_load(5'd4, 4'b1100);
        drive_id(1'b1, 5'd1, 5'd4, 5'd2, 4'b0100);
        #1;
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL rms_stall: got %0b want 1", stall_out); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL rms_stall_out: got %0b want 0", stall_out); end
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rms_valid: got %0b want 0", ex_valid); end
        n_checks++; if (ex_opA !== 32'h0) begin n_fail++; $display("FAIL rms_opA: got %h want 0", ex_opA); end
        n_checks++; if (ex_opB !== 32'h0) begin n_fail++; $display("FAIL rms_opB: got %h want 0", ex_opB); end
        n_checks++; if (ex_imm !== 32'h0) begin n_fail++; $display("FAIL rms_imm: got %h want 0", ex_imm); end
        n_checks++; if (ex_rw !== 5'd0) begin n_fail++; $display("FAIL rms_rw: got %0d want 0", ex_rw); end
        n_checks++; if (ex_ctrl !== 4'h0) begin n_fail++; $display("FAIL rms_ctrl: got %b want 0000", ex_ctrl); end
        n_checks++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL rms_count: got %h want 0", stall_count); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_class();
        test_flush();
`ifdef ID_EX_FORWARD_EN
        test_fwd_priority();
        test_fwd_class();
        test_load_use();
`else
        test_no_fwd();
        test_saturation();
`endif
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
